// File: rtl/fp_add_sub.sv
// -----------------------------------------------------------------------------
// fp_add_sub
//
// Fully pipelined IEEE-754 binary32 adder/subtractor. A new {a, b, operation}
// is accepted on every rising edge with no handshake. Operands captured at
// edge N produce result/flags after edge N+4.
//
// Pipeline:
//   input regs : capture a, b, operation
//   S1         : unpack, effective sign of B, swap so |A| >= |B|, specials
//   S2         : align smaller significand, keep guard/round/sticky
//   S3         : add/subtract extended significands, leading-zero count
//   S4         : normalise, round-to-nearest-even, pack, flags (output regs)
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset, clears every stage
//   a          in  32  operand A (binary32)
//   b          in  32  operand B (binary32)
//   operation  in   1  0 = A+B, 1 = A-B
//   result     out 32  registered binary32 result
//   flags      out  5  registered {NaN, overflow, underflow, zero, inexact}
// -----------------------------------------------------------------------------
module fp_add_sub (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        operation,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam int          F_NAN  = 4;
  localparam int          F_OVF  = 3;
  localparam int          F_UNF  = 2;
  localparam int          F_ZERO = 1;
  localparam int          F_INEX = 0;

  // Result fully decided in S1 (NaN / infinity) rides down the pipe untouched.
  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  flags;
  } special_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
  } in_t;

  typedef struct packed {
    logic        sign;       // sign of the larger-magnitude operand
    logic        eff_sub;    // operand signs differ after the op adjustment
    logic [7:0]  exp;        // exponent of the larger operand
    logic [7:0]  diff;       // exponent difference, always >= 0
    logic [23:0] sig_big;    // significands with hidden bit restored
    logic [23:0] sig_small;
    special_t    spec;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic        eff_sub;
    logic [7:0]  exp;
    logic [26:0] sig_big;    // {significand, guard, round, sticky}
    logic [26:0] sig_small;
    special_t    spec;
  } s2_t;

  typedef struct packed {
    logic        sign;
    logic        eff_sub;
    logic [7:0]  exp;
    logic [27:0] sum;        // bit 27 is the carry out of an addition
    logic [4:0]  lzc;        // leading zeros of sum, 28 when sum is zero
    special_t    spec;
  } s3_t;

  in_t  r_in;
  s1_t  r_s1;
  s2_t  r_s2;
  s3_t  r_s3;
  logic [31:0] r_result;
  logic [4:0]  r_flags;

  s1_t  w_s1;
  s2_t  w_s2;
  s3_t  w_s3;
  logic [31:0] w_result;
  logic [4:0]  w_flags;

  assign result = r_result;
  assign flags  = r_flags;

  // Leading-zero count of a 28-bit vector; the highest set bit wins because
  // later loop iterations overwrite earlier ones.
  function automatic logic [4:0] lzc28(input logic [27:0] v);
    lzc28 = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (v[i]) lzc28 = 5'(27 - i);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // S1: unpack, effective sign, magnitude swap, special operands
  // ---------------------------------------------------------------------------
  logic [7:0]  w_exp_a, w_exp_b;
  logic [22:0] w_frac_a, w_frac_b;
  logic [23:0] w_sig_a, w_sig_b;
  logic        w_sign_a, w_sign_b;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic        w_swap;

  assign w_exp_a  = r_in.a[30:23];
  assign w_exp_b  = r_in.b[30:23];
  // Subnormal inputs are treated as signed zero: drop the fraction.
  assign w_frac_a = (w_exp_a == 8'd0) ? 23'd0 : r_in.a[22:0];
  assign w_frac_b = (w_exp_b == 8'd0) ? 23'd0 : r_in.b[22:0];
  assign w_sig_a  = {w_exp_a != 8'd0, w_frac_a};
  assign w_sig_b  = {w_exp_b != 8'd0, w_frac_b};
  assign w_sign_a = r_in.a[31];
  assign w_sign_b = r_in.b[31] ^ r_in.op;
  assign w_nan_a  = (w_exp_a == 8'hFF) && (w_frac_a != 23'd0);
  assign w_nan_b  = (w_exp_b == 8'hFF) && (w_frac_b != 23'd0);
  assign w_inf_a  = (w_exp_a == 8'hFF) && (w_frac_a == 23'd0);
  assign w_inf_b  = (w_exp_b == 8'hFF) && (w_frac_b == 23'd0);
  // {exp, frac} orders magnitudes of finite values correctly.
  assign w_swap   = {w_exp_b, w_frac_b} > {w_exp_a, w_frac_a};

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    w_s1         = '0;
    w_s1.eff_sub = w_sign_a ^ w_sign_b;
    if (w_swap) begin
      w_s1.sign      = w_sign_b;
      w_s1.exp       = w_exp_b;
      w_s1.diff      = w_exp_b - w_exp_a;
      w_s1.sig_big   = w_sig_b;
      w_s1.sig_small = w_sig_a;
    end else begin
      w_s1.sign      = w_sign_a;
      w_s1.exp       = w_exp_a;
      w_s1.diff      = w_exp_a - w_exp_b;
      w_s1.sig_big   = w_sig_a;
      w_s1.sig_small = w_sig_b;
    end

    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && w_s1.eff_sub)) begin
      w_s1.spec.valid        = 1'b1;
      w_s1.spec.result       = QNAN;
      w_s1.spec.flags[F_NAN] = 1'b1;
    end else if (w_inf_a) begin
      w_s1.spec.valid  = 1'b1;
      w_s1.spec.result = {w_sign_a, 8'hFF, 23'd0};
    end else if (w_inf_b) begin
      w_s1.spec.valid  = 1'b1;
      w_s1.spec.result = {w_sign_b, 8'hFF, 23'd0};
    end
  end

  // ---------------------------------------------------------------------------
  // S2: alignment. The smaller significand is placed above 26 zero bits and
  // shifted; bits landing in [25:24] become guard/round, the rest ORs into
  // sticky. At a difference of 26 or more nothing survives but sticky.
  // ---------------------------------------------------------------------------
  logic [49:0] w_shifted;

  assign w_shifted = {r_s1.sig_small, 26'd0} >> r_s1.diff;

  always_comb begin
    w_s2         = '0;
    w_s2.sign    = r_s1.sign;
    w_s2.eff_sub = r_s1.eff_sub;
    w_s2.exp     = r_s1.exp;
    w_s2.spec    = r_s1.spec;
    w_s2.sig_big = {r_s1.sig_big, 3'b000};
    if (r_s1.diff >= 8'd26) begin
      w_s2.sig_small = {26'd0, |r_s1.sig_small};
    end else begin
      w_s2.sig_small = {w_shifted[49:24], |w_shifted[23:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // S3: significand add/subtract. The swap guarantees big >= small, so the
  // subtraction never goes negative.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_s3         = '0;
    w_s3.sign    = r_s2.sign;
    w_s3.eff_sub = r_s2.eff_sub;
    w_s3.exp     = r_s2.exp;
    w_s3.spec    = r_s2.spec;
    if (r_s2.eff_sub) begin
      w_s3.sum = {1'b0, r_s2.sig_big} - {1'b0, r_s2.sig_small};
    end else begin
      w_s3.sum = {1'b0, r_s2.sig_big} + {1'b0, r_s2.sig_small};
    end
    w_s3.lzc = lzc28(w_s3.sum);
  end

  // ---------------------------------------------------------------------------
  // S4: normalise so the leading one sits at bit 27, round, pack.
  // Shifting by lzc covers both the carry case (lzc = 0, one right step
  // relative to the hidden-bit position) and cancellation (left steps).
  // A left shift of more than one only happens when the exponents differ by
  // at most one, so no sticky information is lost by shifting zeros in.
  // ---------------------------------------------------------------------------
  logic [27:0]       w_norm;
  logic [23:0]       w_sig;
  logic              w_guard, w_round, w_sticky, w_round_up, w_inexact;
  logic [24:0]       w_sig_rnd;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp_norm, w_exp_rnd;

  assign w_norm     = r_s3.sum << r_s3.lzc;
  assign w_sig      = w_norm[27:4];
  assign w_guard    = w_norm[3];
  assign w_round    = w_norm[2];
  assign w_sticky   = |w_norm[1:0];
  assign w_inexact  = w_guard | w_round | w_sticky;
  // Ties go to the even significand.
  assign w_round_up = w_guard & (w_round | w_sticky | w_sig[0]);
  assign w_sig_rnd  = {1'b0, w_sig} + 25'(w_round_up);
  assign w_exp_norm = $signed({2'b00, r_s3.exp}) + 10'sd1 - $signed({5'd0, r_s3.lzc});
  // Rounding carry out of 1.111..1 yields 10.000..0: bump exponent, frac 0.
  assign w_exp_rnd  = w_exp_norm + (w_sig_rnd[24] ? 10'sd1 : 10'sd0);
  assign w_frac     = w_sig_rnd[24] ? w_sig_rnd[23:1] : w_sig_rnd[22:0];

  always_comb begin
    w_result = '0;
    w_flags  = '0;
    if (r_s3.spec.valid) begin
      w_result = r_s3.spec.result;
      w_flags  = r_s3.spec.flags;
    end else if (r_s3.sum == 28'd0) begin
      // Only two zero operands can sum to zero without subtraction, so the
      // shared sign is kept; exact cancellation always gives +0.
      w_result         = {r_s3.eff_sub ? 1'b0 : r_s3.sign, 31'd0};
      w_flags[F_ZERO]  = 1'b1;
    end else if (w_exp_rnd >= 10'sd255) begin
      w_result         = {r_s3.sign, 8'hFF, 23'd0};
      w_flags[F_OVF]   = 1'b1;
      w_flags[F_INEX]  = 1'b1;
    end else if (w_exp_rnd <= 10'sd0) begin
      // Subnormal results flush to +0.
      w_result         = 32'd0;
      w_flags[F_UNF]   = 1'b1;
      w_flags[F_ZERO]  = 1'b1;
      w_flags[F_INEX]  = w_inexact;
    end else begin
      w_result         = {r_s3.sign, w_exp_rnd[7:0], w_frac};
      w_flags[F_INEX]  = w_inexact;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before this edge.
    if (rst) begin
      // NOTE: every stage register is cleared, not just the outputs, so any
      // operation in flight when reset arrives is discarded.
      r_in     <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_s3     <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_in.a   <= a;
      r_in.b   <= b;
      r_in.op  <= operation;
      r_s1     <= w_s1;
      r_s2     <= w_s2;
      r_s3     <= w_s3;
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end

endmodule

// File: tb/tb_fp_add_sub.sv
// -----------------------------------------------------------------------------
// tb_fp_add_sub
//
// Scoreboard bench for fp_add_sub. The stimulus process drives directed
// vectors (expected values worked out by hand for round-to-nearest-even
// binary32) and pushes each expectation with the cycle on which it is due.
// A monitor samples result/flags 1 time unit after every rising edge and
// compares whatever is due on that cycle.
// -----------------------------------------------------------------------------
module tb_fp_add_sub;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        operation;
  logic [31:0] result;
  logic [4:0]  flags;

  fp_add_sub dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .operation (operation),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    bit          chk_flg;
    int          due;
    int          id;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  // flags = {NaN, overflow, underflow, zero, inexact}
  vec_t vecs [18] = '{
    '{32'h4108815B, 32'h40472F14, 1'b1, 32'h40AD6B2C, 5'b00000}, // 0  8.53-3.11
    '{32'h40D8839B, 32'h3F5AC89E, 1'b0, 32'h40F3DCAF, 5'b00001}, // 1  GRS=110, round up
    '{32'hC0BA4F3B, 32'h40981A84, 1'b0, 32'hBF88D2DC, 5'b00000}, // 2  left-shift by 2
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 5'b00010}, // 3  exact cancel
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'b01001}, // 4  overflow
    '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 5'b10000}, // 5  inf-inf
    '{32'h3F800000, 32'h32800000, 1'b1, 32'h3F800000, 5'b00001}, // 6  1-2^-26, sticky only
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5'b00001}, // 7  tie, stays even
    '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 5'b00001}, // 8  tie, rounds to even
    '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 5'b01001}, // 9  overflow by rounding
    '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 5'b00110}, // 10 subnormal result
    '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 5'b00000}, // 11 subnormal input
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 5'b00010}, // 12 (-0)+(-0)
    '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 5'b00000}, // 13 -inf + finite
    '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 5'b00000}, // 14 finite - inf
    '{32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000}, // 15 NaN input
    '{32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 5'b00000}, // 16 2-3, sign from B
    '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 5'b00010}  // 17 (-0)-(+0)
  };

  // Drive one operation at a falling edge; it is sampled on the next rising
  // edge (cyc+1) and must appear four edges after that.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_in, input logic top,
                       input logic [31:0] er, input logic [4:0] ef, input int id);
    exp_t e;
    a         = ta;
    b         = tb_in;
    operation = top;
    e.res     = er;
    e.flg     = ef;
    e.chk_flg = 1'b1;
    e.due     = cyc + 5;
    e.id      = id;
    q.push_back(e);
  endtask

  task automatic expect_at(input int due, input logic [31:0] er, input logic [4:0] ef,
                           input bit chk_flg, input int id);
    exp_t e;
    e.res     = er;
    e.flg     = ef;
    e.chk_flg = chk_flg;
    e.due     = due;
    e.id      = id;
    q.push_back(e);
  endtask

  // Monitor
  always @(posedge clk) begin
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("result[id %0d]", e.id), result, e.res);
      if (e.chk_flg) check($sformatf("flags[id %0d]", e.id), {27'd0, flags}, {27'd0, e.flg});
    end
  end

  // Stimulus
  initial begin
    rst       = 1'b1;
    a         = 32'd0;
    b         = 32'd0;
    operation = 1'b0;

    // Reset edge itself clears the outputs.
    @(negedge clk);
    @(negedge clk);
    expect_at(cyc + 1, 32'd0, 5'b00000, 1'b1, -1);
    @(negedge clk);
    rst = 1'b0;
    // First operation after reset: zeros give +0 with zero flag.
    issue(32'd0, 32'd0, 1'b0, 32'd0, 5'b00010, 100);

    // All directed vectors back to back, one per cycle.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, i);
    end

    // Let the stream drain (idle cycles are not checked).
    repeat (6) begin
      @(negedge clk);
      a = 32'd0; b = 32'd0; operation = 1'b0;
    end

    // Three operations in flight, then reset: none of them may emerge.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, 200 + i);
    end
    @(negedge clk);
    q.delete();
    rst = 1'b1;
    a = 32'd0; b = 32'd0; operation = 1'b0;
    expect_at(cyc + 1, 32'd0, 5'b00000, 1'b1, -2);
    // Cleared stages drain out as zero results where the in-flight
    // operations would otherwise have appeared.
    for (int k = 2; k <= 5; k++) expect_at(cyc + k, 32'd0, 5'b00000, 1'b0, -10 - k);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd0, 32'd0, 1'b0, 32'd0, 5'b00010, 300);
    @(negedge clk);
    issue(vecs[4].a, vecs[4].b, vecs[4].op, vecs[4].res, vecs[4].flg, 304);
    @(negedge clk);
    issue(vecs[16].a, vecs[16].b, vecs[16].op, vecs[16].res, vecs[16].flg, 316);
    @(negedge clk);
    a = 32'd0; b = 32'd0; operation = 1'b0;

    // Bounded wait for the scoreboard to empty.
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
